// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
//
// Pays out the customer's remaining balance through a coin hopper. It always
// picks the largest coin that still fits (greedy change-making). A return
// starts when the user asks for it, or when the machine has been idle long
// enough for the wait timer to run out. Each coin is requested from the
// hopper and held until the hopper acknowledges it. Each accepted coin is
// reported once on the subtract port, so the balance owner can debit it.
//
// Optional feature (macro CHANGE_ACK_TIMEOUT_EN):
//   When defined, a hopper that gives no acknowledge for 16 DISPENSE cycles
//   aborts the return: o_fault pulses and the FSM goes to DONE. When not
//   defined, the FSM waits for the acknowledge forever and o_fault is
//   tied to 0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   i_total             current balance (read only while idle)
//   i_coin_in           coin-inserted pulse (reloads idle timer)
//   i_item_out          item-dispensed pulse (reloads idle timer)
//   i_trigger_return    user return request
//   i_coin_value        NUM_COINS x 32-bit coin values, index 0 smallest
//   o_hopper_req        hopper dispense request
//   o_hopper_sel        one-hot coin select, zero when no request
//   i_hopper_ack        hopper accepted the requested coin
//   o_sub_valid         one-cycle debit pulse
//   o_sub_amount        debit amount, zero when o_sub_valid is low
//   o_busy              return in progress (SELECT / DISPENSE)
//   o_done              one-cycle return-complete pulse
//   o_fault             one-cycle hopper-timeout pulse
//   o_wait_time         idle countdown
// -----------------------------------------------------------------------------
module change_dispense_ctrl #(
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 31,
  parameter int TIMEOUT    = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [TOTAL_BITS-1:0]   i_total,
  input  logic                    i_coin_in,
  input  logic                    i_item_out,
  input  logic                    i_trigger_return,
  input  logic [NUM_COINS*32-1:0] i_coin_value,
  output logic                    o_hopper_req,
  output logic [NUM_COINS-1:0]    o_hopper_sel,
  input  logic                    i_hopper_ack,
  output logic                    o_sub_valid,
  output logic [TOTAL_BITS-1:0]   o_sub_amount,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_fault,
  output logic [31:0]             o_wait_time
);

  // Coin values and the balance are compared at a common width, so that
  // neither side gets truncated.
  localparam int CW = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   rem_q, rem_d;
  logic [31:0]             wait_q, wait_d;
  logic [NUM_COINS-1:0]    sel_q, sel_d;
  logic [TOTAL_BITS-1:0]   coin_q, coin_d;
  logic                    sub_valid_q, sub_valid_d;
  logic [TOTAL_BITS-1:0]   sub_amount_q, sub_amount_d;

  // Greedy pick: values ascend with the index, so the last match in an
  // ascending scan is the largest coin that still fits.
  logic                    pick_found;
  logic [NUM_COINS-1:0]    pick_sel;
  logic [TOTAL_BITS-1:0]   pick_val;

  always_comb begin
    pick_found = 1'b0;
    pick_sel   = '0;
    pick_val   = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_coin_value[i*32 +: 32] != 32'd0 &&
          CW'(i_coin_value[i*32 +: 32]) <= CW'(rem_q)) begin
        pick_found = 1'b1;
        pick_sel   = NUM_COINS'(1) << i;
        // Fits in TOTAL_BITS because the value is <= rem_q.
        pick_val   = TOTAL_BITS'(i_coin_value[i*32 +: 32]);
      end
    end
  end

`ifdef CHANGE_ACK_TIMEOUT_EN
  logic [3:0] ack_cnt_q, ack_cnt_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case statement. This
    // keeps any path that does not assign it from inferring a latch.
    state_d      = state_q;
    rem_d        = rem_q;
    wait_d       = wait_q;
    sel_d        = sel_q;
    coin_d       = coin_q;
    sub_valid_d  = 1'b0;
    sub_amount_d = '0;
`ifdef CHANGE_ACK_TIMEOUT_EN
    ack_cnt_d    = ack_cnt_q;
    fault_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_coin_in || i_item_out) begin
          wait_d = 32'(TIMEOUT);
        end else if (i_total != '0 && wait_q != 32'd0) begin
          wait_d = wait_q - 32'd1;
        end
        if (i_total != '0 && (i_trigger_return || wait_q == 32'd0)) begin
          rem_d   = i_total;
          state_d = SELECT;
        end else if (i_trigger_return) begin
          state_d = DONE;
        end
      end
      SELECT: begin
        if (pick_found) begin
          sel_d   = pick_sel;
          coin_d  = pick_val;
          state_d = DISPENSE;
`ifdef CHANGE_ACK_TIMEOUT_EN
          ack_cnt_d = '0;
`endif
        end else begin
          // Whatever cannot be paid stays in the caller's balance.
          sel_d   = '0;
          state_d = DONE;
        end
      end
      DISPENSE: begin
        if (i_hopper_ack) begin
          rem_d        = rem_q - coin_q;
          sub_valid_d  = 1'b1;
          sub_amount_d = coin_q;
          sel_d        = '0;
          state_d      = SELECT;
        end
`ifdef CHANGE_ACK_TIMEOUT_EN
        else if (ack_cnt_q == 4'd15) begin
          fault_d = 1'b1;
          sel_d   = '0;
          state_d = DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
`endif
      end
      DONE: begin
        wait_d  = 32'(TIMEOUT);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // Every register then samples the pre-edge values, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      wait_q       <= 32'(TIMEOUT);
      sel_q        <= '0;
      coin_q       <= '0;
      sub_valid_q  <= 1'b0;
      sub_amount_q <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      wait_q       <= wait_d;
      sel_q        <= sel_d;
      coin_q       <= coin_d;
      sub_valid_q  <= sub_valid_d;
      sub_amount_q <= sub_amount_d;
    end
  end

`ifdef CHANGE_ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      fault_q   <= fault_d;
    end
  end
  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

  // The outputs are decoded from the state register. A reset therefore
  // clears them at once, without waiting for a clock edge.
  assign o_hopper_req = (state_q == DISPENSE);
  assign o_hopper_sel = o_hopper_req ? sel_q : '0;
  assign o_busy       = (state_q == SELECT) || (state_q == DISPENSE);
  assign o_done       = (state_q == DONE);
  assign o_sub_valid  = sub_valid_q;
  assign o_sub_amount = sub_amount_q;
  assign o_wait_time  = wait_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_change_dispense_ctrl
//
// The bench plays two parts. It is the balance owner: it debits i_total on
// each o_sub_valid. It is also the hopper: it acknowledges each request
// after a configurable delay. The expected payout is the greedy coin list,
// worked out with plain arithmetic from the coin values and the balance.
// -----------------------------------------------------------------------------
module tb_change_dispense_ctrl;

  localparam int NC      = 3;
  localparam int TB_BITS = 31;
  localparam int TMO     = 100;

  logic                 clk;
  logic                 reset_n;
  logic [TB_BITS-1:0]   i_total;
  logic                 i_coin_in, i_item_out, i_trigger_return;
  logic [NC*32-1:0]     i_coin_value;
  logic                 o_hopper_req;
  logic [NC-1:0]        o_hopper_sel;
  logic                 i_hopper_ack;
  logic                 o_sub_valid;
  logic [TB_BITS-1:0]   o_sub_amount;
  logic                 o_busy, o_done, o_fault;
  logic [31:0]          o_wait_time;

  change_dispense_ctrl #(.NUM_COINS(NC), .TOTAL_BITS(TB_BITS), .TIMEOUT(TMO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_total          (i_total),
    .i_coin_in        (i_coin_in),
    .i_item_out       (i_item_out),
    .i_trigger_return (i_trigger_return),
    .i_coin_value     (i_coin_value),
    .o_hopper_req     (o_hopper_req),
    .o_hopper_sel     (o_hopper_sel),
    .i_hopper_ack     (i_hopper_ack),
    .o_sub_valid      (o_sub_valid),
    .o_sub_amount     (o_sub_amount),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_fault          (o_fault),
    .o_wait_time      (o_wait_time)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model state.
  int unsigned coin_v[NC];
  int unsigned exp_q[$];
  int unsigned exp_rem;

  task automatic set_coins(input int unsigned a, input int unsigned b, input int unsigned c);
    coin_v[0] = a; coin_v[1] = b; coin_v[2] = c;
    i_coin_value = {c, b, a};
  endtask

  // Greedy change: as many of the largest coin as fit, then the next one down.
  task automatic setup_exp(input int unsigned total);
    int unsigned rem;
    exp_q.delete();
    rem = total;
    for (int i = NC - 1; i >= 0; i--) begin
      if (coin_v[i] != 0) begin
        while (rem >= coin_v[i]) begin
          exp_q.push_back(coin_v[i]);
          rem -= coin_v[i];
        end
      end
    end
    exp_rem = rem;
  endtask

  function automatic int unsigned sel_value(input logic [NC-1:0] s);
    if ($countones(s) != 1) return 32'hFFFF_FFFF;
    for (int i = 0; i < NC; i++) if (s[i]) return coin_v[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Properties that must hold on every cycle outside reset.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!o_hopper_req) check("sel_zero_when_idle", 64'(o_hopper_sel), 64'd0);
      if (!o_sub_valid)  check("amount_zero_when_invalid", 64'(o_sub_amount), 64'd0);
`ifndef CHANGE_ACK_TIMEOUT_EN
      check("fault_tied_low", 64'(o_fault), 64'd0);
`endif
    end
  end

  // Request a return with the given balance. After this the trigger has
  // been sampled and the outputs for that edge are visible.
  task automatic trigger_return(input int unsigned total);
    i_total = TB_BITS'(total);
    setup_exp(total);
    i_trigger_return = 1'b1;
    step();
    i_trigger_return = 1'b0;
    if (total != 0) begin
      check("trig_busy", 64'(o_busy), 64'd1);
      check("trig_req_not_yet", 64'(o_hopper_req), 64'd0);
    end
  endtask

  // Act as the hopper and the balance owner until o_done appears, then
  // check the payout against the model.
  task automatic run_return(input int ack_delay, input bit noise, input bit chk_lat);
    int unsigned n_exp, coins, req_cycles, expv;
    logic [NC-1:0] held_sel;
    bit done_seen;
    n_exp = exp_q.size();
    coins = 0;
    req_cycles = 0;
    held_sel = '0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc == 0 && chk_lat) check("latency_req", 64'(o_hopper_req), 64'(n_exp != 0));
      if (o_sub_valid) begin
        check("req_gap", 64'(o_hopper_req), 64'd0);
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
        check("sub_amount", 64'(o_sub_amount), 64'(expv));
        i_total = i_total - o_sub_amount;
        coins++;
      end
      if (o_hopper_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          held_sel = o_hopper_sel;
          if (exp_q.size() != 0) check("sel_coin", 64'(sel_value(o_hopper_sel)), 64'(exp_q[0]));
          else                   check("unexpected_req", 64'd1, 64'd0);
        end else begin
          check("sel_stable", 64'(o_hopper_sel), 64'(held_sel));
        end
        i_hopper_ack = (req_cycles >= ack_delay);
      end else begin
        req_cycles = 0;
        i_hopper_ack = 1'b0;
      end
      if (noise && o_busy) {i_coin_in, i_item_out, i_trigger_return} = 3'($urandom);
      else                 {i_coin_in, i_item_out, i_trigger_return} = 3'b000;
      if (o_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(done_seen), 64'd1);
    check("coin_count", 64'(coins), 64'(n_exp));
    check("remainder", 64'(i_total), 64'(exp_rem));
    {i_coin_in, i_item_out, i_trigger_return, i_hopper_ack} = 4'b0000;
    step();
    check("done_one_cycle", 64'(o_done), 64'd0);
    check("wait_reload_after_done", 64'(o_wait_time), 64'(TMO));
    check("idle_after_done", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_w, a, b, c, tot;
    reset_n = 1'b0;
    i_total = '0;
    {i_coin_in, i_item_out, i_trigger_return, i_hopper_ack} = 4'b0000;
    set_coins(100, 500, 1000);
    #23;
    check("rst_wait", 64'(o_wait_time), 64'(TMO));
    check("rst_req", 64'(o_hopper_req), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_sub_valid", 64'(o_sub_valid), 64'd0);
    check("rst_fault", 64'(o_fault), 64'd0);
    reset_n = 1'b1;
    step();
    check("idle_hold_zero_total", 64'(o_wait_time), 64'(TMO));

    // Return requested with an empty balance.
    trigger_return(0);
    check("zero_done", 64'(o_done), 64'd1);
    check("zero_busy", 64'(o_busy), 64'd0);
    check("zero_req", 64'(o_hopper_req), 64'd0);
    step();
    check("zero_done_once", 64'(o_done), 64'd0);

    // 1600 pays 1000, 500, 100.
    trigger_return(1600);
    run_return(2, 1'b0, 1'b1);

    // 150 pays one 100 coin; 50 cannot be returned.
    trigger_return(150);
    run_return(2, 1'b0, 1'b1);

    // Idle timer: coin reload at 5, then a full countdown to an automatic
    // return. The timer currently reads TMO.
    i_total = TB_BITS'(100);
    exp_w = TMO;
    while (exp_w > 5) begin
      step();
      exp_w--;
      check("wait_count_pre", 64'(o_wait_time), 64'(exp_w));
    end
    i_coin_in = 1'b1;
    step();
    i_coin_in = 1'b0;
    check("wait_reload_coin", 64'(o_wait_time), 64'(TMO));
    exp_w = TMO;
    while (exp_w > 0) begin
      step();
      exp_w--;
      check("wait_count", 64'(o_wait_time), 64'(exp_w));
    end
    setup_exp(100);
    step();
    check("timeout_select", 64'(o_busy), 64'd1);
    run_return(2, 1'b0, 1'b1);

    // Hopper that does not acknowledge.
    trigger_return(500);
    step();
`ifdef CHANGE_ACK_TIMEOUT_EN
    for (int n = 1; n <= 16; n++) begin
      check("hold_req", 64'(o_hopper_req), 64'd1);
      step();
    end
    check("fault_pulse", 64'(o_fault), 64'd1);
    check("fault_done", 64'(o_done), 64'd1);
    check("fault_req_low", 64'(o_hopper_req), 64'd0);
    check("fault_no_sub", 64'(o_sub_valid), 64'd0);
    step();
    check("fault_one_cycle", 64'(o_fault), 64'd0);
    check("fault_wait_reload", 64'(o_wait_time), 64'(TMO));
`else
    for (int n = 1; n <= 20; n++) begin
      check("hold_req", 64'(o_hopper_req), 64'd1);
      check("hold_no_sub", 64'(o_sub_valid), 64'd0);
      if (n < 20) step();
    end
    run_return(1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of DISPENSE.
    trigger_return(1000);
    step();
    check("pre_reset_req", 64'(o_hopper_req), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_req_drop", 64'(o_hopper_req), 64'd0);
    check("async_sel_drop", 64'(o_hopper_sel), 64'd0);
    check("async_busy_drop", 64'(o_busy), 64'd0);
    #1 reset_n = 1'b1;
    check("post_reset_wait", 64'(o_wait_time), 64'(TMO));
    check("post_reset_idle", 64'(o_busy), 64'd0);
    step();
    check("first_edge_idle_dec", 64'(o_wait_time), 64'(TMO - 1));
    check("first_edge_no_req", 64'(o_hopper_req), 64'd0);
    i_total = '0;

    // Random coin sets, balances, ack delays and ignored inputs while busy.
    for (int it = 0; it < 30; it++) begin
      a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(20, 200);
      b = a + $urandom_range(1, 400);
      c = b + $urandom_range(1, 1000);
      set_coins(a, b, c);
      tot = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4000);
      trigger_return(tot);
      if (tot == 0) begin
        check("rnd_zero_done", 64'(o_done), 64'd1);
        check("rnd_zero_req", 64'(o_hopper_req), 64'd0);
        step();
      end else begin
        run_return($urandom_range(1, 4), 1'b1, 1'b1);
      end
      i_total = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
